multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 255, giving the maximum cycles spent waiting for mem_ready in one memory state (range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port opcode, input, 7 bits: instruction[6:0] from the instruction register.
REQ-005 The block SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-006 The block SHALL have port mem_ready, input, 1 bit: memory completion for the current read or write.
REQ-007 The block SHALL have port pc_write, output, 1 bit: PC load strobe.
REQ-008 The block SHALL have port ir_write, output, 1 bit: IR and old-PC load strobe.
REQ-009 The block SHALL have ports mem_read and mem_write, output, 1 bit each: memory request strobes.
REQ-010 The block SHALL have port reg_write, output, 1 bit: register-file write strobe.
REQ-011 The block SHALL have port alu_op, output, 2 bits, driven to the ALU decoder: 00 add, 01 sub (branch compare), 10 funct-decoded.
REQ-012 The block SHALL have port alu_src_a, output, 2 bits: 00 PC, 01 old PC, 10 rs1.
REQ-013 The block SHALL have port alu_src_b, output, 2 bits: 00 rs2, 01 immediate, 10 constant 4.
REQ-014 The block SHALL have port result_src, output, 2 bits: 00 ALU-out register, 01 memory data, 10 live ALU result.
REQ-015 The block SHALL have port state, output, 4 bits: current state encoding.
REQ-016 The block SHALL have port trap_cause, output, 2 bits: 00 none, 01 illegal opcode, 10 memory timeout.
REQ-017 The block SHALL have port retired, output, 32 bits: count of completed instructions.

Function
REQ-018 The block SHALL use states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXEC_R=6, EXEC_I=7, ALUWB=8, BRANCH=9, TRAP=10.
REQ-019 Unlisted strobes SHALL be 0; unlisted selects SHALL be 00.
REQ-020 FETCH SHALL drive mem_read=1, alu_src_b=10, alu_op=00, result_src=10; it SHALL pulse pc_write=ir_write=1 and go to DECODE in the cycle mem_ready=1, and otherwise hold.
REQ-021 DECODE SHALL drive alu_src_a=01, alu_src_b=01, alu_op=00 (branch target into ALU-out).
REQ-022 DECODE next state SHALL depend on opcode: 0000011 or 0100011 -> MEMADR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BRANCH; any other opcode -> TRAP with trap_cause=01.
REQ-023 MEMADR SHALL drive alu_src_a=10, alu_src_b=01, alu_op=00, then go to MEMREAD if opcode[5]=0, else to MEMWRITE.
REQ-024 MEMREAD SHALL drive mem_read=1, result_src=00, and go to MEMWB on mem_ready.
REQ-025 MEMWB SHALL drive result_src=01 and reg_write=1, then go to FETCH.
REQ-026 MEMWRITE SHALL drive mem_write=1, result_src=00, and go to FETCH on mem_ready.
REQ-027 EXEC_R SHALL drive alu_src_a=10, alu_src_b=00, alu_op=10; EXEC_I SHALL drive alu_src_a=10, alu_src_b=01, alu_op=10; both SHALL then go to ALUWB.
REQ-028 ALUWB SHALL drive result_src=00 and reg_write=1, then go to FETCH.
REQ-029 BRANCH SHALL drive alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, with pc_write=zero (combinational), then go to FETCH.
REQ-030 pc_write and ir_write in FETCH, and pc_write in BRANCH, SHALL be Mealy outputs; all other outputs SHALL decode from state only.
REQ-031 A wait counter SHALL clear on every state change and increment each cycle spent in FETCH, MEMREAD or MEMWRITE while mem_ready=0.
REQ-032 When the wait counter reaches MEM_TIMEOUT with mem_ready=0, the next state SHALL be TRAP with trap_cause=10; mem_ready=1 in that same cycle SHALL take priority over the timeout.
REQ-033 TRAP SHALL drive all strobes 0 and hold state and trap_cause until reset.
REQ-034 retired SHALL increment by 1, wrapping modulo 2^32, on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH.

Reset
REQ-035 Asserting rst_n low SHALL immediately set state=FETCH, trap_cause=00, retired=0 and wait counter=0, and force pc_write, ir_write, mem_read, mem_write and reg_write to 0 while rst_n is low.
REQ-036 Reset asserted mid-instruction, including in TRAP, SHALL abandon the instruction without incrementing retired.
REQ-037 Fetch SHALL resume on the first rising edge of clk after rst_n goes high.

Verification
REQ-038 Scenario add: opcode 0110011, mem_ready=1 in FETCH -> states 0,1,6,8,0; reg_write high only in state 8; retired=1.
REQ-039 Scenario load: opcode 0000011, mem_ready delayed 3 cycles in MEMREAD -> states 0,1,2,3,3,3,3,4,0; result_src=01 with reg_write=1 in state 4.
REQ-040 Scenario branch: opcode 1100011 with zero=1 -> pc_write=1 in BRANCH; repeated with zero=0 -> pc_write=0; retired increments in both cases.
REQ-041 Scenario illegal: opcode 1111111 -> TRAP and trap_cause=01, all strobes 0 for 20 cycles, retired unchanged.
REQ-042 Scenario timeout: MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP and trap_cause=10 after 4 wait cycles; a second run with mem_ready=1 on the 4th wait cycle -> DECODE.
REQ-043 Scenario reset: rst_n pulsed low in MEMWRITE between clock edges -> mem_write falls immediately; state=0, retired=0; fetch resumes on the first edge after release.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V style control unit: sequences fetch/decode/execute/memory/writeback,
// guards memory waits with a timeout, traps on illegal opcodes and counts retired instructions.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic [1:0]  alu_op,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic [3:0]  state,
  output logic [1:0]  trap_cause,
  output logic [31:0] retired
);

  localparam int unsigned WAIT_W = 8;
  localparam int unsigned RET_W  = 32;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_TRAP     = 4'd10
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  state_e             state_q, state_d;
  logic [1:0]         trap_q, trap_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [RET_W-1:0]   retired_q, retired_d;
  logic               mem_wait;
  logic               timeout;
  logic               retire;

  // Next-state, trap, wait-counter and retire bookkeeping
  always_comb begin
    state_d   = state_q;
    trap_d    = trap_q;
    mem_wait  = ((state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                 (state_q == S_MEMWRITE)) && !mem_ready;
    // Counter already at the limit and memory still not ready: give up
    timeout   = mem_wait && (wait_q == WAIT_W'(MEM_TIMEOUT));

    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          default: begin
            state_d = S_TRAP;
            trap_d  = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEMADR:   state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXEC_R:   state_d = S_ALUWB;
      S_EXEC_I:   state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_TRAP;
    endcase

    if (timeout) begin
      state_d = S_TRAP;
      trap_d  = CAUSE_TIMEOUT;
    end

    if (state_d != state_q) begin
      wait_d = '0;
    end else if (mem_wait) begin
      wait_d = wait_q + WAIT_W'(1);
    end else begin
      wait_d = wait_q;
    end

    retire    = (state_d == S_FETCH) &&
                ((state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
                 (state_q == S_ALUWB) || (state_q == S_BRANCH));
    retired_d = retire ? (retired_q + RET_W'(1)) : retired_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      trap_q    <= CAUSE_NONE;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      trap_q    <= trap_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  // Datapath controls decoded from the state register; FETCH/BRANCH strobes follow inputs
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_op     = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;

    case (state_q)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_write   = mem_ready;
        ir_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD:  mem_read = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: mem_write = 1'b1;
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB:    reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = zero;
      end
      default: ;
    endcase

    // Strobes must drop the instant reset is asserted, not at the next edge
    if (!rst_n) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign state      = state_q;
  assign trap_cause = trap_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed vector table, hand-written reset/trap/timeout
// sequences, then random traffic checked against an instruction-path reference model.
module tb_multicycle_ctrl;

  localparam int unsigned TIMEOUT = 4;

  localparam logic [6:0] OP_L   = 7'b0000011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_ILL = 7'b1111111;

  localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5;
  localparam int EXEC_R = 6, EXEC_I = 7, ALUWB = 8, BRANCH = 9, TRAP = 10;

  logic        clk;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, ir_write, mem_read, mem_write, reg_write;
  logic [1:0]  alu_op, alu_src_a, alu_src_b, result_src;
  logic [3:0]  state;
  logic [1:0]  trap_cause;
  logic [31:0] retired;

  multicycle_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .alu_op     (alu_op),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .state      (state),
    .trap_cause (trap_cause),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        pcw, irw, mr, mw, rw;
    logic [1:0]  aop, asa, asb, rsrc;
    logic [3:0]  st;
    logic [1:0]  tc;
    logic [31:0] ret;
  } obs_t;

  typedef struct packed {
    logic       mr, mw, rw;
    logic [1:0] aop, asa, asb, rsrc;
  } sout_t;

  typedef struct {
    logic [6:0]  opc;
    logic        z, rdy;
    logic [3:0]  st;
    logic        pcw, irw, mr, mw, rw;
    logic [1:0]  rsrc;
    logic [31:0] ret;
  } vec_t;

  int    n_cmp, n_err;
  vec_t  vecs[$];
  sout_t out_tab[0:10];

  int          m_state;
  int          m_wait;
  logic [1:0]  m_cause;
  logic [31:0] m_ret;
  int          m_path[$];

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t sample();
    obs_t o;
    o = '{pcw: pc_write, irw: ir_write, mr: mem_read, mw: mem_write, rw: reg_write,
          aop: alu_op, asa: alu_src_a, asb: alu_src_b, rsrc: result_src,
          st: state, tc: trap_cause, ret: retired};
    return o;
  endfunction

  function automatic sout_t so(input logic mr, input logic mw, input logic rw, input logic [1:0] aop,
                               input logic [1:0] asa, input logic [1:0] asb, input logic [1:0] rsrc);
    sout_t s;
    s = '{mr: mr, mw: mw, rw: rw, aop: aop, asa: asa, asb: asb, rsrc: rsrc};
    return s;
  endfunction

  function automatic vec_t mk(input logic [6:0] opc, input logic z, input logic rdy, input logic [3:0] st,
                              input logic pcw, input logic irw, input logic mr, input logic mw,
                              input logic rw, input logic [1:0] rsrc, input logic [31:0] ret);
    vec_t v;
    v.opc = opc; v.z = z; v.rdy = rdy; v.st = st; v.pcw = pcw; v.irw = irw;
    v.mr = mr; v.mw = mw; v.rw = rw; v.rsrc = rsrc; v.ret = ret;
    return v;
  endfunction

  task automatic model_reset();
    m_state = FETCH;
    m_wait  = 0;
    m_cause = 2'b00;
    m_ret   = 32'd0;
    m_path.delete();
  endtask

  function automatic obs_t model_expect(input logic rdy, input logic z, input logic rstn);
    obs_t  e;
    sout_t o;
    o     = out_tab[m_state];
    e.pcw = rstn && (((m_state == FETCH) && rdy) || ((m_state == BRANCH) && z));
    e.irw = rstn && (m_state == FETCH) && rdy;
    e.mr  = rstn && o.mr;
    e.mw  = rstn && o.mw;
    e.rw  = rstn && o.rw;
    e.aop = o.aop;
    e.asa = o.asa;
    e.asb = o.asb;
    e.rsrc = o.rsrc;
    e.st  = 4'(m_state);
    e.tc  = m_cause;
    e.ret = m_ret;
    return e;
  endfunction

  // One clock of the reference: memory states wait, otherwise follow the instruction's path
  task automatic model_step(input logic [6:0] opc, input logic rdy);
    if (m_state == TRAP) return;
    if (((m_state == FETCH) || (m_state == MEMREAD) || (m_state == MEMWRITE)) && !rdy) begin
      if (m_wait == int'(TIMEOUT)) begin
        m_state = TRAP;
        m_cause = 2'b10;
        m_wait  = 0;
      end else begin
        m_wait++;
      end
      return;
    end
    m_wait = 0;
    if (m_state == FETCH) begin
      m_state = DECODE;
      return;
    end
    if (m_state == DECODE) begin
      m_path.delete();
      case (opc)
        OP_L: begin m_path.push_back(MEMADR); m_path.push_back(MEMREAD); m_path.push_back(MEMWB); end
        OP_S: begin m_path.push_back(MEMADR); m_path.push_back(MEMWRITE); end
        OP_R: begin m_path.push_back(EXEC_R); m_path.push_back(ALUWB); end
        OP_I: begin m_path.push_back(EXEC_I); m_path.push_back(ALUWB); end
        OP_B: m_path.push_back(BRANCH);
        default: begin
          m_state = TRAP;
          m_cause = 2'b01;
          return;
        end
      endcase
    end
    if (m_path.size() == 0) begin
      m_state = FETCH;
      m_ret++;
    end else begin
      m_state = m_path.pop_front();
    end
  endtask

  function automatic logic [6:0] pick_op();
    int r;
    r = int'($urandom_range(0, 19));
    if (r < 4)  return OP_L;
    if (r < 7)  return OP_S;
    if (r < 11) return OP_R;
    if (r < 15) return OP_I;
    if (r < 18) return OP_B;
    return 7'($urandom);
  endfunction

  initial begin
    int trap_cnt;
    logic r_rst;
    n_cmp = 0;
    n_err = 0;

    out_tab[FETCH]    = so(1, 0, 0, 2'b00, 2'b00, 2'b10, 2'b10);
    out_tab[DECODE]   = so(0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00);
    out_tab[MEMADR]   = so(0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00);
    out_tab[MEMREAD]  = so(1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    out_tab[MEMWB]    = so(0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b01);
    out_tab[MEMWRITE] = so(0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    out_tab[EXEC_R]   = so(0, 0, 0, 2'b10, 2'b10, 2'b00, 2'b00);
    out_tab[EXEC_I]   = so(0, 0, 0, 2'b10, 2'b10, 2'b01, 2'b00);
    out_tab[ALUWB]    = so(0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    out_tab[BRANCH]   = so(0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00);
    out_tab[TRAP]     = so(0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);

    //                  opc  z  rdy st pcw irw mr mw rw rsrc   ret
    vecs.push_back(mk(OP_R, 0, 1, 0, 1, 1, 1, 0, 0, 2'b10, 0));
    vecs.push_back(mk(OP_R, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 0));
    vecs.push_back(mk(OP_R, 0, 1, 6, 0, 0, 0, 0, 0, 2'b00, 0));
    vecs.push_back(mk(OP_R, 0, 1, 8, 0, 0, 0, 0, 1, 2'b00, 0));
    vecs.push_back(mk(OP_L, 0, 1, 0, 1, 1, 1, 0, 0, 2'b10, 1));
    vecs.push_back(mk(OP_L, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 1));
    vecs.push_back(mk(OP_L, 0, 1, 2, 0, 0, 0, 0, 0, 2'b00, 1));
    vecs.push_back(mk(OP_L, 0, 0, 3, 0, 0, 1, 0, 0, 2'b00, 1));
    vecs.push_back(mk(OP_L, 0, 0, 3, 0, 0, 1, 0, 0, 2'b00, 1));
    vecs.push_back(mk(OP_L, 0, 0, 3, 0, 0, 1, 0, 0, 2'b00, 1));
    vecs.push_back(mk(OP_L, 0, 1, 3, 0, 0, 1, 0, 0, 2'b00, 1));
    vecs.push_back(mk(OP_L, 0, 1, 4, 0, 0, 0, 0, 1, 2'b01, 1));
    vecs.push_back(mk(OP_B, 1, 1, 0, 1, 1, 1, 0, 0, 2'b10, 2));
    vecs.push_back(mk(OP_B, 1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2));
    vecs.push_back(mk(OP_B, 1, 1, 9, 1, 0, 0, 0, 0, 2'b00, 2));
    vecs.push_back(mk(OP_B, 0, 1, 0, 1, 1, 1, 0, 0, 2'b10, 3));
    vecs.push_back(mk(OP_B, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 3));
    vecs.push_back(mk(OP_B, 0, 1, 9, 0, 0, 0, 0, 0, 2'b00, 3));
    vecs.push_back(mk(OP_S, 0, 1, 0, 1, 1, 1, 0, 0, 2'b10, 4));
    vecs.push_back(mk(OP_S, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 4));
    vecs.push_back(mk(OP_S, 0, 1, 2, 0, 0, 0, 0, 0, 2'b00, 4));
    vecs.push_back(mk(OP_S, 0, 0, 5, 0, 0, 0, 1, 0, 2'b00, 4));
    vecs.push_back(mk(OP_S, 0, 1, 5, 0, 0, 0, 1, 0, 2'b00, 4));
    vecs.push_back(mk(OP_I, 0, 1, 0, 1, 1, 1, 0, 0, 2'b10, 5));
    vecs.push_back(mk(OP_I, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 5));
    vecs.push_back(mk(OP_I, 0, 1, 7, 0, 0, 0, 0, 0, 2'b00, 5));
    vecs.push_back(mk(OP_I, 0, 1, 8, 0, 0, 0, 0, 1, 2'b00, 5));

    // Reset state, with mem_ready high to show the FETCH strobes are held off
    rst_n = 1'b0; opcode = OP_R; zero = 1'b1; mem_ready = 1'b1;
    #12;
    check_val("reset_state", 64'({state, trap_cause, retired}), 64'({4'd0, 2'b00, 32'd0}));
    check_val("reset_strobes", 64'({pc_write, ir_write, mem_read, mem_write, reg_write}), 64'(5'b0));
    tick();
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      opcode = vecs[i].opc; zero = vecs[i].z; mem_ready = vecs[i].rdy;
      @(negedge clk);
      check_val($sformatf("vec%0d", i),
                64'({state, pc_write, ir_write, mem_read, mem_write, reg_write, result_src, retired}),
                64'({vecs[i].st, vecs[i].pcw, vecs[i].irw, vecs[i].mr, vecs[i].mw, vecs[i].rw,
                     vecs[i].rsrc, vecs[i].ret}));
      tick();
    end
    check_val("retired_after_table", 64'(retired), 64'd6);

    // Illegal opcode: trap and sit there with everything quiet
    opcode = OP_ILL; mem_ready = 1'b1; zero = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_val($sformatf("illegal_trap%0d", i),
                64'({state, trap_cause, pc_write, ir_write, mem_read, mem_write, reg_write, retired}),
                64'({4'd10, 2'b01, 5'b0, 32'd6}));
      tick();
    end

    // Reset while in TRAP
    rst_n = 1'b0;
    #1;
    check_val("trap_reset", 64'({state, trap_cause, retired}), 64'({4'd0, 2'b00, 32'd0}));
    #2;
    opcode = OP_R; mem_ready = 1'b0;
    rst_n = 1'b1;

    // Timeout in FETCH: counter reaches 4 after four waits, the next waiting cycle traps
    repeat (4) tick();
    @(negedge clk);
    check_val("timeout_still_fetch", 64'({state, trap_cause}), 64'({4'd0, 2'b00}));
    tick();
    @(negedge clk);
    check_val("timeout_trap", 64'({state, trap_cause}), 64'({4'd10, 2'b10}));

    // Same, but memory answers in the cycle the timeout would fire
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    repeat (4) tick();
    mem_ready = 1'b1;
    @(negedge clk);
    check_val("ready_beats_timeout_strobe", 64'({state, pc_write, ir_write}), 64'({4'd0, 1'b1, 1'b1}));
    tick();
    check_val("ready_beats_timeout_state", 64'({state, trap_cause}), 64'({4'd1, 2'b00}));

    // Finish the add, then reset asynchronously in the middle of a store
    repeat (3) tick();
    check_val("add_retired", 64'({state, retired}), 64'({4'd0, 32'd1}));
    opcode = OP_S;
    repeat (3) tick();
    mem_ready = 1'b0;
    @(negedge clk);
    check_val("store_memwrite", 64'({state, mem_write, retired}), 64'({4'd5, 1'b1, 32'd1}));
    #2 rst_n = 1'b0;
    #1;
    check_val("async_reset_memwrite", 64'({state, mem_write, retired}), 64'({4'd0, 1'b0, 32'd0}));
    #1 rst_n = 1'b1;
    mem_ready = 1'b1;
    tick();
    check_val("fetch_resumes", 64'(state), 64'd1);

    // Random traffic against the reference model
    model_reset();
    trap_cnt = 0;
    for (int i = 0; i < 4000; i++) begin
      r_rst = (i < 2) || ((m_state == TRAP) && (trap_cnt >= 3)) || ($urandom_range(0, 299) == 0);
      rst_n = !r_rst;
      if (m_state == FETCH) opcode = pick_op();
      zero = 1'($urandom_range(0, 1));
      mem_ready = ($urandom_range(0, 9) < 6);
      if (r_rst) model_reset();
      trap_cnt = (m_state == TRAP) ? trap_cnt + 1 : 0;
      @(negedge clk);
      check_val($sformatf("random%0d", i), 64'(sample()), 64'(model_expect(mem_ready, zero, rst_n)));
      if (!r_rst) model_step(opcode, mem_ready);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
